// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner.
// Holds the default refresh divider, the digit count, the digit index type,
// the all-off drive patterns and the 16-entry active-low hex glyph table
// (bit 0 = segment a ... bit 6 = segment g).
package seg_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;
  localparam int unsigned NUM_DIGITS          = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the glyph for nibble value n; listed from F down to 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   i_nibble - 4-bit hex value
//   o_seg    - active-low segments, o_seg[0]=a ... o_seg[6]=g
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    o_seg = GLYPH_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// A prescaler divides clk into digit slots of REFRESH_DIV cycles; a 2-bit
// index walks the digits 0..3. Displayed values come from shadow registers
// that are only updated while load is high. All outputs are registered and
// follow the index/shadow state with one clock of latency.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   load   - capture digits/blank/dp_in into the shadow registers
//   digits - four hex nibbles, digits[4k+3:4k] is digit k (k=0 rightmost)
//   blank  - blank[k]=1 switches digit k fully off
//   dp_in  - dp_in[k]=1 lights the decimal point of digit k
//   an     - active-low digit anodes, at most one low
//   seg    - active-low segment cathodes, seg[0]=a ... seg[6]=g
//   dp     - active-low decimal-point cathode
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned      CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_presc;
  digit_idx_t       r_idx;
  logic [15:0]      r_digits;
  logic [3:0]       r_blank;
  logic [3:0]       r_dp_sh;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tick;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  // Slot tick at the prescaler terminal count.
  always_comb begin
    w_tick = (r_presc == TERM);
  end

  // Select the nibble and the anode pattern of the digit currently indexed.
  always_comb begin
    w_nibble = 4'h0;
    w_an_nxt = AN_OFF;
    case (r_idx)
      2'd0: begin
        w_nibble = r_digits[3:0];
        w_an_nxt = 4'b1110;
      end
      2'd1: begin
        w_nibble = r_digits[7:4];
        w_an_nxt = 4'b1101;
      end
      2'd2: begin
        w_nibble = r_digits[11:8];
        w_an_nxt = 4'b1011;
      end
      2'd3: begin
        w_nibble = r_digits[15:12];
        w_an_nxt = 4'b0111;
      end
      default: begin
        w_nibble = 4'h0;
        w_an_nxt = AN_OFF;
      end
    endcase
  end

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // A blanked digit keeps its slot time but drives everything off.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (r_blank[r_idx]) begin
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
    end else begin
      w_seg_nxt = w_glyph;
      w_dp_nxt  = ~r_dp_sh[r_idx];
    end
  end

  // Prescaler, digit index, shadow registers and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_idx    <= 2'd0;
      r_digits <= 16'h0000;
      r_blank  <= 4'b1111;
      r_dp_sh  <= 4'b0000;
      r_an     <= AN_OFF;
      r_seg    <= SEG_OFF;
      r_dp     <= 1'b1;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + ONE;
      end
      if (load) begin
        r_digits <= digits;
        r_blank  <= blank;
        r_dp_sh  <= dp_in;
      end
      r_an  <= r_blank[r_idx] ? AN_OFF : w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
